// File: rtl/fetch_pc_unit_pkg.sv
// Shared CPU definitions: datapath widths, fetch state encoding and the
// branch-offset sign extension used by fetch and decode.
package cpu_pkg;

  localparam int PC_W     = 16;
  localparam int OFFSET_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  function automatic logic [PC_W-1:0] sign_extend(input logic [OFFSET_W-1:0] offset);
    return {{(PC_W-OFFSET_W){offset[OFFSET_W-1]}}, offset};
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Decoder-to-fetch control bundle plus the fetch status returned to the core.
interface fetch_pc_unit_if import cpu_pkg::*; ();

  // No valid/ready pair here: every control line is a level sampled on each
  // rising edge while in RUN (start also in IDLE/HALTED); there is no backpressure.
  logic                start;
  logic                stall;
  logic                branch_taken;
  logic [OFFSET_W-1:0] branch_offset;
  logic                jump_en;
  logic [PC_W-1:0]     jump_target;
  logic                halt_req;

  logic [PC_W-1:0]     pc_out;
  logic                running;
  logic                done;
  logic [PC_W-1:0]     cycle_count;
  fetch_state_t        state;

  modport master (
    output start, stall, branch_taken, branch_offset, jump_en, jump_target, halt_req,
    input  pc_out, running, done, cycle_count, state
  );

  modport slave (
    input  start, stall, branch_taken, branch_offset, jump_en, jump_target, halt_req,
    output pc_out, running, done, cycle_count, state
  );

endinterface

// File: rtl/fetch_pc_unit_next_pc.sv
// Combinational next-PC selection for a RUN cycle: halt/stall hold, then
// jump, then relative branch, then sequential increment, all modulo 2^16.
module fetch_next_pc import cpu_pkg::*; (
  input  logic [PC_W-1:0]     pc,
  input  logic                halt_req,
  input  logic                stall,
  input  logic                jump_en,
  input  logic [PC_W-1:0]     jump_target,
  input  logic                branch_taken,
  input  logic [OFFSET_W-1:0] branch_offset,
  output logic [PC_W-1:0]     next_pc
);

  always_comb begin
    next_pc = pc + 16'd1;
    // A halting instruction keeps the PC on itself so it stays observable.
    if (halt_req || stall) begin
      next_pc = pc;
    end else if (jump_en) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = pc + sign_extend(branch_offset);
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and fetch sequencer: IDLE/RUN/HALTED control, PC register
// and a saturating count of RUN cycles since the last start.
module fetch_pc_unit import cpu_pkg::*; #(
  parameter logic [PC_W-1:0] START_ADDR = 16'd0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_pc_unit_if.slave bus
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] count_q, count_d;
  logic [PC_W-1:0] pc_run;

  fetch_next_pc u_next_pc (
    .pc            (pc_q),
    .halt_req      (bus.halt_req),
    .stall         (bus.stall),
    .jump_en       (bus.jump_en),
    .jump_target   (bus.jump_target),
    .branch_taken  (bus.branch_taken),
    .branch_offset (bus.branch_offset),
    .next_pc       (pc_run)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (bus.start) begin
          state_d = ST_RUN;
          pc_d    = START_ADDR;
          count_d = '0;
        end
      end
      ST_RUN: begin
        pc_d    = pc_run;
        // Stalled and halting cycles still count as executed RUN cycles.
        count_d = (count_q == {PC_W{1'b1}}) ? count_q : count_q + 16'd1;
        if (bus.halt_req) begin
          state_d = ST_HALTED;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = START_ADDR;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= START_ADDR;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.running     = (state_q == ST_RUN);
  assign bus.done        = (state_q == ST_HALTED);
  assign bus.cycle_count = count_q;
  assign bus.state       = state_q;

endmodule
